// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer with valid/ready on the input side.
// Ready depends only on buffer state and grant, never on valid.
module wb_hold_buf
    import regfile_pkg::*;
#(
    parameter int RD_W  = 5,
    parameter int DAT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    output logic             ready,
    input  logic [RD_W-1:0]  rd,
    input  logic [DAT_W-1:0] data,
    input  logic             grant,
    output logic             full,
    output logic [RD_W-1:0]  held_rd,
    output logic [DAT_W-1:0] held_data
);

    buf_state_t state;
    logic       accept;

    assign ready  = (state == BUF_EMPTY) || grant;
    assign accept = valid && ready;
    assign full   = (state == BUF_FULL);

    // A grant with a same-cycle accept refills the entry and stays FULL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BUF_EMPTY;
            held_rd   <= '0;
            held_data <= '0;
        end else if (accept) begin
            state     <= BUF_FULL;
            held_rd   <= rd;
            held_data <= data;
        end else if (grant) begin
            state     <= BUF_EMPTY;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin writeback arbiter for the register file write port.
// Define REGFILE_ARB_ZERO_GUARD_EN to suppress writes to r0 and drop r0 from stall.
module regfile_write_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] Write_data,
    input  logic [ADDR_W-1:0] Rs1,
    input  logic [ADDR_W-1:0] Rs2,
    output logic              stall
);

`ifdef REGFILE_ARB_ZERO_GUARD_EN
    localparam bit ZERO_GUARD = 1'b1;
`else
    localparam bit ZERO_GUARD = 1'b0;
`endif

    logic              full0, full1;
    logic [ADDR_W-1:0] held_rd0, held_rd1;
    logic [DATA_W-1:0] held_data0, held_data1;
    logic              grant0, grant1, grant_any, rr_used;
    logic              accept0, accept1;
    logic              rr_ptr, age1_older;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    wb_hold_buf #(.RD_W(ADDR_W), .DAT_W(DATA_W)) u_buf0 (
        .clk       (clk),
        .reset     (reset),
        .valid     (req0_valid),
        .ready     (req0_ready),
        .rd        (req0_rd),
        .data      (req0_data),
        .grant     (grant0),
        .full      (full0),
        .held_rd   (held_rd0),
        .held_data (held_data0)
    );

    wb_hold_buf #(.RD_W(ADDR_W), .DAT_W(DATA_W)) u_buf1 (
        .clk       (clk),
        .reset     (reset),
        .valid     (req1_valid),
        .ready     (req1_ready),
        .rd        (req1_rd),
        .data      (req1_data),
        .grant     (grant1),
        .full      (full1),
        .held_rd   (held_rd1),
        .held_data (held_data1)
    );

    assign accept0   = req0_valid && req0_ready;
    assign accept1   = req1_valid && req1_ready;
    assign grant_any = grant0 || grant1;

    // Same destination: oldest first keeps write order; otherwise rr_ptr decides.
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        rr_used = 1'b0;
        if (full0 && full1) begin
            if (held_rd0 == held_rd1) begin
                if (age1_older) grant1 = 1'b1;
                else            grant0 = 1'b1;
            end else begin
                rr_used = 1'b1;
                if (rr_ptr) grant1 = 1'b1;
                else        grant0 = 1'b1;
            end
        end else if (full0) begin
            grant0 = 1'b1;
        end else if (full1) begin
            grant1 = 1'b1;
        end
    end

    always_comb begin
        sel_rd   = grant1 ? held_rd1   : held_rd0;
        sel_data = grant1 ? held_data1 : held_data0;
    end

    function automatic logic rd_hazard(input logic [ADDR_W-1:0] rd,
                                       input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
        return ((rd == a) || (rd == b)) && !(ZERO_GUARD && (rd == '0));
    endfunction

    assign stall = (full0    && rd_hazard(held_rd0, Rs1, Rs2)) ||
                   (full1    && rd_hazard(held_rd1, Rs1, Rs2)) ||
                   (RegWrite && rd_hazard(Rd,       Rs1, Rs2));

    // Age only matters while both are FULL: it is set when buffer 0 refills
    // while buffer 1 keeps its older entry, and cleared by any other change.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite   <= 1'b0;
            Rd         <= '0;
            Write_data <= '0;
            rr_ptr     <= 1'b0;
            age1_older <= 1'b0;
        end else begin
            if (grant_any && !(ZERO_GUARD && (sel_rd == '0))) begin
                RegWrite   <= 1'b1;
                Rd         <= sel_rd;
                Write_data <= sel_data;
            end else begin
                RegWrite   <= 1'b0;
            end
            if (rr_used)
                rr_ptr <= ~rr_ptr;
            if (accept0 || accept1 || grant_any)
                age1_older <= accept0 && !accept1 && full1 && !grant1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed tables, corner sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_rd, req1_rd;
    logic [15:0] req0_data, req1_data;
    logic        RegWrite;
    logic [4:0]  Rd;
    logic [15:0] Write_data;
    logic [4:0]  Rs1, Rs2;
    logic        stall;

    int errors = 0;
    int checks = 0;

`ifdef REGFILE_ARB_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .RegWrite   (RegWrite),
        .Rd         (Rd),
        .Write_data (Write_data),
        .Rs1        (Rs1),
        .Rs2        (Rs2),
        .stall      (stall)
    );

    // Reference model: slots with fill timestamps, round-robin bit, output register.
    bit        m_full [2];
    wb_entry_t m_ent  [2];
    int        m_stamp[2];
    int        m_rr;
    int        m_cyc;
    bit        m_we;
    logic [4:0]  m_rd;
    logic [15:0] m_data;
    bit          s_stall, s_rdy0, s_rdy1;

    function automatic bit m_hit(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return ((rd == a) || (rd == b)) && !(GUARD && rd == 5'd0);
    endfunction

    function automatic int m_grant();
        if (m_full[0] && m_full[1]) begin
            if (m_ent[0].rd == m_ent[1].rd)
                return (m_stamp[1] < m_stamp[0]) ? 1 : 0;
            return m_rr;
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_rr = 0; m_we = 0; m_rd = '0; m_data = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one cycle of inputs, checks combinational and registered outputs
    // against the model mid-cycle, then advances the model past the edge.
    task automatic step(input bit v0, input logic [4:0] r0, input logic [15:0] d0,
                        input bit v1, input logic [4:0] r1, input logic [15:0] d1,
                        input logic [4:0] s1, input logic [4:0] s2);
        int  g;
        bit  e0, e1, a0, a1, contended;
        wb_entry_t sel;
        req0_valid = v0; req0_rd = r0; req0_data = d0;
        req1_valid = v1; req1_rd = r1; req1_data = d1;
        Rs1 = s1; Rs2 = s2;
        @(negedge clk);
        g  = m_grant();
        e0 = !m_full[0] || (g == 0);
        e1 = !m_full[1] || (g == 1);
        contended = m_full[0] && m_full[1] && (m_ent[0].rd != m_ent[1].rd);
        s_rdy0  = req0_ready;
        s_rdy1  = req1_ready;
        s_stall = stall;
        chk("ready0", {31'd0, req0_ready}, {31'd0, e0});
        chk("ready1", {31'd0, req1_ready}, {31'd0, e1});
        chk("stall", {31'd0, stall},
            {31'd0, (m_full[0] && m_hit(m_ent[0].rd, s1, s2)) ||
                    (m_full[1] && m_hit(m_ent[1].rd, s1, s2)) ||
                    (m_we && m_hit(m_rd, s1, s2))});
        chk("RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
        chk("Rd", {27'd0, Rd}, {27'd0, m_rd});
        chk("Write_data", {16'd0, Write_data}, {16'd0, m_data});
        a0 = v0 && e0;
        a1 = v1 && e1;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            sel = m_ent[g];
            if (contended) m_rr = 1 - m_rr;
            if (GUARD && sel.rd == 5'd0) m_we = 0;
            else begin m_we = 1; m_rd = sel.rd; m_data = sel.data; end
        end else begin
            m_we = 0;
        end
        if (a0) begin m_full[0] = 1; m_ent[0] = '{rd: r0, data: d0}; m_stamp[0] = m_cyc; end
        else if (g == 0) m_full[0] = 0;
        if (a1) begin m_full[1] = 1; m_ent[1] = '{rd: r1, data: d1}; m_stamp[1] = m_cyc; end
        else if (g == 1) m_full[1] = 0;
        m_cyc++;
    endtask

    task automatic idle();
        step(0, 5'd0, 16'd0, 0, 5'd0, 16'd0, 5'd0, 5'd0);
    endtask

    task automatic expect_write(input string name, input logic [4:0] rd, input logic [15:0] data);
        chk({name, "_we"}, {31'd0, RegWrite}, 32'd1);
        chk({name, "_rd"}, {27'd0, Rd}, {27'd0, rd});
        chk({name, "_data"}, {16'd0, Write_data}, {16'd0, data});
    endtask

    typedef struct {
        bit          port;
        logic [4:0]  rd;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{port: 1'b0, rd: 5'd3,  data: 16'hABCD};
        tbl[1] = '{port: 1'b1, rd: 5'd17, data: 16'h1234};
        tbl[2] = '{port: 1'b0, rd: 5'd31, data: 16'hFFFF};
        tbl[3] = '{port: 1'b1, rd: 5'd1,  data: 16'h0000};
        tbl[4] = '{port: 1'b0, rd: 5'd30, data: 16'h5A5A};
        m_cyc = 0;
        req0_rd = '0; req0_data = '0; req1_rd = '0; req1_data = '0;
        Rs1 = '0; Rs2 = '0;

        // Reset state
        do_reset(2);
        chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_Rd", {27'd0, Rd}, 32'd0);
        chk("rst_Write_data", {16'd0, Write_data}, 32'd0);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd1);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // Single writer table: one-cycle pulse, write appears once, next cycle
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].port == 1'b0) step(1, tbl[i].rd, tbl[i].data, 0, 5'd0, 16'd0, 5'd0, 5'd0);
            else                     step(0, 5'd0, 16'd0, 1, tbl[i].rd, tbl[i].data, 5'd0, 5'd0);
            chk("single_lat", {31'd0, RegWrite}, 32'd0);
            idle();
            expect_write("single", tbl[i].rd, tbl[i].data);
            idle();
            chk("single_once", {31'd0, RegWrite}, 32'd0);
        end

        // Contention, different rd: rr toggles between contended grants
        do_reset(1);
        step(1, 5'd4, 16'h0004, 1, 5'd5, 16'h0005, 5'd0, 5'd0);
        idle(); expect_write("cont_a1", 5'd4, 16'h0004);
        idle(); expect_write("cont_a2", 5'd5, 16'h0005);
        step(1, 5'd6, 16'h0006, 1, 5'd7, 16'h0007, 5'd0, 5'd0);
        idle(); expect_write("cont_b1", 5'd7, 16'h0007);
        idle(); expect_write("cont_b2", 5'd6, 16'h0006);
        idle(); chk("cont_done", {31'd0, RegWrite}, 32'd0);

        // Same-rd ordering: buffer 1 captures rd9 first while buffer 0 is busy
        do_reset(1);
        step(1, 5'd20, 16'h0020, 1, 5'd21, 16'h0021, 5'd0, 5'd0);
        step(1, 5'd22, 16'h0022, 0, 5'd0, 16'd0, 5'd0, 5'd0);
        expect_write("ord_20", 5'd20, 16'h0020);
        step(0, 5'd0, 16'd0, 1, 5'd9, 16'd1, 5'd0, 5'd0);
        chk("ord_rdy1", {31'd0, s_rdy1}, 32'd1);
        expect_write("ord_21", 5'd21, 16'h0021);
        step(1, 5'd9, 16'd2, 0, 5'd0, 16'd0, 5'd0, 5'd0);
        chk("ord_rdy0", {31'd0, s_rdy0}, 32'd1);
        expect_write("ord_22", 5'd22, 16'h0022);
        idle(); expect_write("ord_first", 5'd9, 16'd1);
        idle(); expect_write("ord_second", 5'd9, 16'd2);

        // Hazard on rd=12 through buffer and output stage
        do_reset(1);
        step(1, 5'd12, 16'h00CC, 0, 5'd0, 16'd0, 5'd12, 5'd0);
        step(0, 5'd0, 16'd0, 0, 5'd0, 16'd0, 5'd12, 5'd0);
        chk("haz_buf", {31'd0, s_stall}, 32'd1);
        step(0, 5'd0, 16'd0, 0, 5'd0, 16'd0, 5'd12, 5'd0);
        chk("haz_out", {31'd0, s_stall}, 32'd1);
        step(0, 5'd0, 16'd0, 0, 5'd0, 16'd0, 5'd12, 5'd0);
        chk("haz_clear", {31'd0, s_stall}, 32'd0);
        step(1, 5'd12, 16'h00CC, 0, 5'd0, 16'd0, 5'd13, 5'd0);
        step(0, 5'd0, 16'd0, 0, 5'd0, 16'd0, 5'd13, 5'd0);
        chk("haz_other", {31'd0, s_stall}, 32'd0);
        idle(); idle();

        // Reset mid-operation discards both buffered writes
        step(1, 5'd1, 16'h1111, 1, 5'd2, 16'h2222, 5'd0, 5'd0);
        do_reset(1);
        chk("mid_ready0", {31'd0, req0_ready}, 32'd1);
        chk("mid_ready1", {31'd0, req1_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_nowrite", {31'd0, RegWrite}, 32'd0);
            idle();
        end

`ifdef REGFILE_ARB_ZERO_GUARD_EN
        // r0 writes are drained silently and never stall
        do_reset(1);
        step(1, 5'd0, 16'h0BAD, 0, 5'd0, 16'd0, 5'd0, 5'd0);
        step(0, 5'd0, 16'd0, 0, 5'd0, 16'd0, 5'd0, 5'd0);
        chk("zg_stall", {31'd0, s_stall}, 32'd0);
        chk("zg_we0", {31'd0, RegWrite}, 32'd0);
        idle();
        chk("zg_we1", {31'd0, RegWrite}, 32'd0);
        chk("zg_ready", {31'd0, req0_ready}, 32'd1);
`endif

        // Randomized traffic against the model, small rd space for collisions
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 16'($urandom),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 16'($urandom),
                     5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
